// File: rtl/mips_cpu_data_mem_responder.sv
// Data-memory slave for the Harvard MIPS core: a word RAM behind the data_read/data_write
// strobes. It inserts WAIT_STATES stall cycles per request and returns load words one cycle after acceptance.
module mips_cpu_data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        stall,
    output logic [31:0] readdata,
    output logic        readvalid,
    output logic        err
);
    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam bit         HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [3:0] CNT_INIT = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t                 state_reg, state_next;
    logic [3:0]             cnt_reg, cnt_next;
    logic [ADDR_WIDTH-1:0]  idx_reg, idx_next;
    logic                   op_rd_reg, op_rd_next;
    logic [3:0]             be_reg, be_next;
    logic [31:0]            wdata_reg, wdata_next;
    logic                   err_reg, err_next;
    logic [31:0]            readdata_reg, readdata_next;

    logic                   req, both, idle_like, in_wait;
    logic                   capture, acc_live, abandon, acc_wait;
    logic                   acc_rd, acc_wr;
    logic [ADDR_WIDTH-1:0]  live_idx, acc_idx;
    logic [3:0]             acc_be;
    logic [31:0]            acc_wdata, rd_word;
    logic                   unused_addr_bits;

    assign live_idx         = address[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{address[31:ADDR_WIDTH+2], address[1:0]};

    // DONE behaves like IDLE for a new request, which is what allows back-to-back accesses.
    assign req       = data_read ^ data_write;
    assign both      = data_read & data_write;
    assign in_wait   = (state_reg == ST_WAIT);
    assign idle_like = !in_wait;

    assign capture   = idle_like && req && HAS_WAIT;
    assign acc_live  = idle_like && req && !HAS_WAIT;
    assign abandon   = in_wait && !data_read && !data_write;
    assign acc_wait  = in_wait && !abandon && (cnt_reg == 4'd0);

    // With zero wait states the live inputs are used; otherwise the captured copy.
    assign acc_rd    = acc_live ? data_read  : (acc_wait && op_rd_reg);
    assign acc_wr    = acc_live ? data_write : (acc_wait && !op_rd_reg);
    assign acc_idx   = acc_live ? live_idx   : idx_reg;
    assign acc_be    = acc_live ? byteenable : be_reg;
    assign acc_wdata = acc_live ? writedata  : wdata_reg;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 4'd0;
            idx_reg      <= '0;
            op_rd_reg    <= 1'b0;
            be_reg       <= 4'd0;
            wdata_reg    <= 32'd0;
            err_reg      <= 1'b0;
            readdata_reg <= 32'd0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            op_rd_reg    <= op_rd_next;
            be_reg       <= be_next;
            wdata_reg    <= wdata_next;
            err_reg      <= err_next;
            readdata_reg <= readdata_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        idx_next      = idx_reg;
        op_rd_next    = op_rd_reg;
        be_next       = be_reg;
        wdata_next    = wdata_reg;
        err_next      = idle_like && both;
        readdata_next = acc_rd ? rd_word : readdata_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                state_next = ST_IDLE;
                if (capture) begin
                    state_next = ST_WAIT;
                    cnt_next   = CNT_INIT;
                    idx_next   = live_idx;
                    op_rd_next = data_read;
                    be_next    = byteenable;
                    wdata_next = writedata;
                end else if (acc_live && data_read) begin
                    state_next = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (abandon) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    state_next = op_rd_reg ? ST_DONE : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        stall     = capture || (in_wait && (cnt_reg != 4'd0));
        readvalid = (state_reg == ST_DONE);
        err       = err_reg;
        readdata  = readdata_reg;
    end

    // One byte-wide RAM per lane so byte enables map onto independent write ports.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];

        always_ff @(posedge clk) begin
            if (acc_wr && acc_be[gi]) begin
                lane_mem[acc_idx] <= acc_wdata[gi*8 +: 8];
            end
        end

        assign rd_word[gi*8 +: 8] = lane_mem[acc_idx];
    end

endmodule

// File: tb/tb_mips_cpu_data_mem_responder.sv
// Scoreboard bench: a W=2 responder under random loads/stores/errors/abandons against a word-array
// model, plus a W=0 instance exercised with byte-enable merges.
module tb_mips_cpu_data_mem_responder;
    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] addr = 32'd0, wd = 32'd0;
    logic        rd = 1'b0, wr = 1'b0;
    logic [3:0]  be = 4'd0;
    logic        stall, rvalid, err;
    logic [31:0] rdata;

    logic [31:0] addr0 = 32'd0, wd0 = 32'd0;
    logic        rd0 = 1'b0, wr0 = 1'b0;
    logic [3:0]  be0 = 4'd0;
    logic        stall0, rvalid0, err0;
    logic [31:0] rdata0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        rq[$];
    int          eq[$];
    logic [31:0] mem_model [1024];

    mips_cpu_data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(W)) dut (
        .clk(clk), .reset_n(reset_n), .address(addr), .data_read(rd), .data_write(wr),
        .byteenable(be), .writedata(wd), .stall(stall), .readdata(rdata),
        .readvalid(rvalid), .err(err)
    );

    mips_cpu_data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(addr0), .data_read(rd0), .data_write(wr0),
        .byteenable(be0), .writedata(wd0), .stall(stall0), .readdata(rdata0),
        .readvalid(rvalid0), .err(err0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // Monitor: every readvalid/err pulse must match the head of its queue.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rvalid) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_readvalid: got readdata %h required no pulse", rdata);
                end else begin
                    exp_t e;
                    e = rq.pop_front();
                    $display("load  readdata=%h expect=%h cycle=%0d", rdata, e.data, cyc);
                    chk("load_data", rdata, e.data);
                    chk("load_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (err) begin
                if (eq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_err: got err 1 required 0");
                end else begin
                    chk("err_cycle", 32'(cyc), 32'(eq.pop_front()));
                end
            end
        end
    end

    task automatic idle(input int n);
        rd = 1'b0; wr = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Presents a request, counts stall cycles, updates the model at acceptance.
    task automatic issue(input bit r, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        int   nst;
        int   idx;
        exp_t e;
        rd = r; wr = !r; addr = a; be = b; wd = d;
        idx = int'(a[11:2]);
        nst = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            nst++;
            if (nst > 20) begin
                checks++; errors++;
                $display("FAIL stall_timeout: stall still high after %0d cycles", nst);
                break;
            end
        end
        chk("stall_cycles", 32'(nst), 32'(W));
        if (r) begin
            e.data = mem_model[idx];
            e.cyc  = cyc + 1;
            rq.push_back(e);
        end else begin
            mem_model[idx] = merge(mem_model[idx], d, b);
        end
        $display("%s addr=%h be=%b data=%h stalls=%0d", r ? "rdreq" : "wrreq", a, b, d, nst);
        @(posedge clk); #1;
    endtask

    task automatic proto_err();
        rd = 1'b1; wr = 1'b1; addr = 32'h40; wd = 32'hFFFF_FFFF; be = 4'hF;
        @(negedge clk);
        chk("err_no_stall", 32'(stall), 32'd0);
        eq.push_back(cyc + 1);
        $display("both strobes raised cycle=%0d", cyc);
        @(posedge clk); #1;
        idle(2);
    endtask

    task automatic abandon_store(input logic [31:0] a);
        rd = 1'b0; wr = 1'b1; addr = a; be = 4'hF; wd = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("abandon_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        $display("store abandoned addr=%h", a);
        idle(3);
        chk("abandon_idle_stall", 32'(stall), 32'd0);
    endtask

    initial begin
        int          kind, idx;
        logic [31:0] a, d;
        logic [3:0]  b;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_readdata", rdata, 32'd0);
        chk("rst_readvalid", 32'(rvalid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_readdata0", rdata0, 32'd0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // Zero-wait-state instance: byte-enable merge with back-to-back requests.
        wr0 = 1'b1; addr0 = 32'h20; be0 = 4'hF; wd0 = 32'h1122_3344;
        @(negedge clk); chk("w0_stall_a", 32'(stall0), 32'd0);
        @(posedge clk); #1;
        be0 = 4'b0101; wd0 = 32'hAABB_CCDD;
        @(negedge clk); chk("w0_stall_b", 32'(stall0), 32'd0);
        @(posedge clk); #1;
        wr0 = 1'b0; rd0 = 1'b1;
        @(negedge clk); chk("w0_stall_c", 32'(stall0), 32'd0);
        chk("w0_no_early_valid", 32'(rvalid0), 32'd0);
        @(posedge clk); #1;
        rd0 = 1'b0;
        @(negedge clk);
        chk("w0_readvalid", 32'(rvalid0), 32'd1);
        chk("w0_readdata", rdata0, 32'h11BB_33DD);
        $display("w0 load readdata=%h", rdata0);
        @(negedge clk);
        chk("w0_readvalid_pulse", 32'(rvalid0), 32'd0);
        chk("w0_readdata_hold", rdata0, 32'h11BB_33DD);
        @(posedge clk); #1;

        // Initialise the words the random phase touches.
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, 32'(i) << 2, 4'hF, $urandom);
            idle(1);
        end

        issue(1'b0, 32'h10, 4'hF, 32'hDEAD_BEEF);
        idle(1);
        issue(1'b1, 32'h10, 4'h0, 32'd0);
        idle(2);

        issue(1'b0, 32'h1004, 4'hF, 32'h5A5A_5A5A);
        issue(1'b1, 32'h0004, 4'h0, 32'd0);
        idle(2);

        abandon_store(32'h10);
        issue(1'b1, 32'h10, 4'h0, 32'd0);
        idle(1);

        proto_err();
        issue(1'b1, 32'h40, 4'h0, 32'd0);
        idle(1);

        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 9);
            idx  = $urandom_range(0, 15);
            a    = ($urandom & 32'hFFFF_F000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
            d    = $urandom;
            b    = 4'($urandom_range(0, 15));
            if (kind < 4) issue(1'b0, a, b, d);
            else if (kind < 8) issue(1'b1, a, 4'h0, 32'd0);
            else if (kind == 8) proto_err();
            else abandon_store(a);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
        end
        idle(2);

        // Reset during a load's wait period.
        issue(1'b0, 32'h10, 4'hF, 32'hCAFE_F00D);
        issue(1'b1, 32'h10, 4'h0, 32'd0);
        idle(2);
        rd = 1'b1; addr = 32'h10;
        @(posedge clk); #1;
        reset_n = 1'b0; rd = 1'b0;
        #1;
        chk("midrst_readvalid", 32'(rvalid), 32'd0);
        chk("midrst_readdata", rdata, 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        idle(4);
        issue(1'b1, 32'h10, 4'h0, 32'd0);
        idle(3);

        chk("rq_drained", 32'(rq.size()), 32'd0);
        chk("eq_drained", 32'(eq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
